// File: rtl/lbus_reg_bridge_pkg.sv
// Local-bus register bridge shared definitions.
// Address map, status and control bit positions.
package lbus_reg_bridge_pkg;

  localparam int unsigned N_WORDS_D = 7;

  localparam logic [15:0] OP_BASE_D   = 16'h0100;
  localparam logic [15:0] OP_LAST_D   = 16'h0110;
  localparam logic [15:0] CTRL_ADDR_D = 16'h0002;
  localparam logic [15:0] STAT_ADDR_D = 16'h0000;
  localparam logic [15:0] RES_ADDR_D  = 16'h0180;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CLR_ERR = 1;

endpackage

// File: rtl/lbus_wr_detect.sv
// Local-bus write strobe detector.
// Tracks previous wrn to find the 1->0 commit edge.
module lbus_wr_detect (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_wrn,
  output logic o_commit,
  output logic o_addr_ph
);

  logic r_wrn_q;

  // previous-cycle wrn level
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_wrn_q <= 1'b0;
    else         r_wrn_q <= i_wrn;
  end

  assign o_commit  = r_wrn_q & ~i_wrn;
  assign o_addr_ph = i_wrn;

endmodule

// File: rtl/lbus_reg_bridge.sv
// Local-bus slave: operand register file, start/status
// control and registered read-back for the crypto core.
module lbus_reg_bridge
  import lbus_reg_bridge_pkg::*;
#(
  parameter int unsigned N_WORDS   = N_WORDS_D,
  parameter logic [15:0] OP_BASE   = OP_BASE_D,
  parameter logic [15:0] OP_LAST   = OP_LAST_D,
  parameter logic [15:0] CTRL_ADDR = CTRL_ADDR_D,
  parameter logic [15:0] STAT_ADDR = STAT_ADDR_D,
  parameter logic [15:0] RES_ADDR  = RES_ADDR_D
) (
  input  logic                   lbus_clkn,
  input  logic                   lbus_rstn,
  input  logic [15:0]            lbus_di_a,
  input  logic                   lbus_wrn,
  input  logic                   lbus_rdn,
  output logic [15:0]            lbus_do,
  output logic [32*N_WORDS-1:0]  op_data,
  output logic                   core_start,
  input  logic                   core_busy,
  input  logic                   core_done,
  input  logic [31:0]            core_result,
  output logic                   err_flag
);

  localparam int SW = $clog2(2*N_WORDS);
  localparam int unsigned LO_HALVES = 2*(N_WORDS-1);

  logic [15:0]           r_addr;
  logic [15:0]           r_do;
  logic [32*N_WORDS-1:0] r_op;
  logic [31:0]           r_res;
  logic                  r_start;
  logic                  r_done;
  logic                  r_err;

  logic [15:0]   w_off;
  logic [15:0]   w_rd;
  logic [SW-1:0] w_sel;
  logic          w_commit;
  logic          w_addr_ph;
  logic          w_op_hit;
  logic          w_ctrl_hit;
  logic          w_stat_hit;
  logic          w_res_lo;
  logic          w_res_hi;
  logic          w_op_wr;
  logic          w_start_set;
  logic          w_err_set;
  logic          w_err_clr;

  lbus_wr_detect u_wr_detect (
    .i_clk     (lbus_clkn),
    .i_rstn    (lbus_rstn),
    .i_wrn     (lbus_wrn),
    .o_commit  (w_commit),
    .o_addr_ph (w_addr_ph)
  );

  assign w_off      = r_addr - OP_BASE;
  assign w_ctrl_hit = (r_addr == CTRL_ADDR);
  assign w_stat_hit = (r_addr == STAT_ADDR);
  assign w_res_lo   = (r_addr == RES_ADDR);
  assign w_res_hi   = (r_addr == RES_ADDR + 16'd1);

  // operand address decode to a 16-bit half index
  always_comb begin
    w_op_hit = 1'b0;
    w_sel    = '0;
    if (w_off < 16'(LO_HALVES)) begin
      w_op_hit = 1'b1;
      w_sel    = w_off[SW-1:0];
    end else if (r_addr == OP_LAST) begin
      w_op_hit = 1'b1;
      w_sel    = SW'(LO_HALVES);
    end else if (r_addr == OP_LAST + 16'd1) begin
      w_op_hit = 1'b1;
      w_sel    = SW'(LO_HALVES + 1);
    end
  end

  assign w_op_wr     = w_commit & w_op_hit & ~core_busy;
  assign w_start_set = w_commit & w_ctrl_hit
                     & lbus_di_a[CTRL_START] & ~core_busy;
  assign w_err_clr   = w_commit & w_ctrl_hit
                     & lbus_di_a[CTRL_CLR_ERR];
  assign w_err_set   = w_commit & core_busy
                     & (w_op_hit
                        | (w_ctrl_hit & lbus_di_a[CTRL_START]));

  // read-back mux over the latched address
  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      w_stat_hit: begin
        w_rd[STAT_BUSY] = core_busy;
        w_rd[STAT_DONE] = r_done;
        w_rd[STAT_ERR]  = r_err;
      end
      w_res_lo: w_rd = r_res[15:0];
      w_res_hi: w_rd = r_res[31:16];
      w_op_hit: w_rd = r_op[{w_sel, 4'b0} +: 16];
      default:  w_rd = '0;
    endcase
  end

  // address latch: last address-phase value wins
  always_ff @(posedge lbus_clkn or negedge lbus_rstn) begin
    if (!lbus_rstn)     r_addr <= '0;
    else if (w_addr_ph) r_addr <= lbus_di_a;
  end

  // operand half-word writes
  always_ff @(posedge lbus_clkn or negedge lbus_rstn) begin
    if (!lbus_rstn)   r_op <= '0;
    else if (w_op_wr) r_op[{w_sel, 4'b0} +: 16] <= lbus_di_a;
  end

  // start pulse, sticky done/err, result capture
  always_ff @(posedge lbus_clkn or negedge lbus_rstn) begin
    if (!lbus_rstn) begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_res   <= '0;
    end else begin
      r_start <= w_start_set;
      r_err   <= (r_err & ~w_err_clr) | w_err_set;
      if (core_done)        r_done <= 1'b1;
      else if (w_start_set) r_done <= 1'b0;
      if (core_done)        r_res  <= core_result;
    end
  end

  // registered read data; a commit takes priority
  always_ff @(posedge lbus_clkn or negedge lbus_rstn) begin
    if (!lbus_rstn)                r_do <= '0;
    else if (!lbus_rdn && !w_commit) r_do <= w_rd;
  end

  assign lbus_do    = r_do;
  assign op_data    = r_op;
  assign core_start = r_start;
  assign err_flag   = r_err;

endmodule

// File: tb/tb_lbus_reg_bridge.sv
// Testbench for lbus_reg_bridge.
// Random bus traffic against an address-map reference model.
module tb_lbus_reg_bridge;

  localparam int NW = 7;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [15:0]     di = '0;
  logic            wrn = 1'b0;
  logic            rdn = 1'b1;
  logic [15:0]     dout;
  logic [32*NW-1:0] op;
  logic            start;
  logic            busy = 1'b0;
  logic            done = 1'b0;
  logic [31:0]     res = '0;
  logic            err;

  always #5 clk = ~clk;

  lbus_reg_bridge dut (
    .lbus_clkn   (clk),
    .lbus_rstn   (rstn),
    .lbus_di_a   (di),
    .lbus_wrn    (wrn),
    .lbus_rdn    (rdn),
    .lbus_do     (dout),
    .op_data     (op),
    .core_start  (start),
    .core_busy   (busy),
    .core_done   (done),
    .core_result (res),
    .err_flag    (err)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] m_mem [0:65535];
  logic        m_err;
  logic        m_done;
  logic [31:0] m_res;
  logic        m_start;

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_op(input logic [15:0] a);
    return (a >= 16'h0100 && a < 16'h010C)
        || a == 16'h0110 || a == 16'h0111;
  endfunction

  function automatic logic [32*NW-1:0] exp_op();
    logic [32*NW-1:0] e;
    logic [15:0] lo;
    e = '0;
    for (int k = 0; k < NW; k++) begin
      lo = (k < NW-1) ? 16'(16'h0100 + 2*k) : 16'h0110;
      e[32*k +: 32] = {m_mem[lo + 16'd1], m_mem[lo]};
    end
    return e;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    if (a == 16'h0000) return {13'b0, m_err, m_done, busy};
    if (a == 16'h0180) return m_res[15:0];
    if (a == 16'h0181) return m_res[31:16];
    if (is_op(a))      return m_mem[a];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_err   = 1'b0;
    m_done  = 1'b0;
    m_res   = '0;
    m_start = 1'b0;
    for (int a = 16'h0100; a <= 16'h0111; a++) m_mem[a] = '0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d,
                    input bit rd_too);
    wrn = 1'b1; di = a; rdn = 1'b1;
    tick();
    wrn = 1'b0; di = d; rdn = rd_too ? 1'b0 : 1'b1;
    tick();
    rdn = 1'b1;
    m_start = 1'b0;
    if (is_op(a)) begin
      if (busy) m_err = 1'b1;
      else      m_mem[a] = d;
    end else if (a == 16'h0002) begin
      if (d[1]) m_err = 1'b0;
      if (d[0]) begin
        if (busy) m_err = 1'b1;
        else begin
          m_start = 1'b1;
          m_done  = 1'b0;
        end
      end
    end
    check("start", 256'(start), 256'(m_start));
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    wrn = 1'b1; di = a; rdn = 1'b1;
    tick();
    rdn = 1'b0;
    tick();
    rdn = 1'b1;
    v = dout;
  endtask

  task automatic rdchk(input string tag, input logic [15:0] a);
    logic [15:0] v;
    rd(a, v);
    check(tag, 256'(v), 256'(exp_rd(a)));
  endtask

  initial begin
    logic [15:0] v;
    logic [31:0] w2;
    logic [15:0] a;
    int r;

    model_reset();
    rstn = 1'b0; wrn = 1'b0; rdn = 1'b1;
    repeat (3) tick();
    check("rst_op", 256'(op), 256'(0));
    check("rst_do", 256'(dout), 256'(0));
    check("rst_start", 256'(start), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    rstn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      di = 16'($urandom);
      tick();
      check("idle_start", 256'(start), 256'(0));
    end
    check("idle_op", 256'(op), 256'(0));
    check("idle_do", 256'(dout), 256'(0));

    wr(16'h0100, 16'h0001, 0);
    wr(16'h0101, 16'h0001, 0);
    check("word0", 256'(op[31:0]), 256'(32'h0001_0001));
    wr(16'h0110, 16'h000D, 0);
    wr(16'h0111, 16'h0001, 0);
    check("word6", 256'(op[223:192]), 256'(32'h0001_000D));
    di = 16'h5555;
    repeat (2) tick();
    check("no_rewrite", 256'(op), 256'(exp_op()));

    for (int k = 0; k < NW; k++) begin
      a = (k < NW-1) ? 16'(16'h0100 + 2*k) : 16'h0110;
      wr(a, 16'($urandom), 0);
      wr(a + 16'd1, 16'($urandom), 0);
    end
    check("full_op", 256'(op), 256'(exp_op()));
    wr(16'h0002, 16'h0001, 0);
    check("start_hi", 256'(start), 256'(1));
    tick();
    check("start_1cyc", 256'(start), 256'(0));

    busy = 1'b1;
    w2 = op[95:64];
    wr(16'h0104, 16'hBEEF, 0);
    wr(16'h0002, 16'h0001, 0);
    check("busy_w2", 256'(op[95:64]), 256'(w2));
    rd(16'h0000, v);
    check("stat_busy", 256'(v), 256'(16'h0005));
    check("err_pin", 256'(err), 256'(1));
    busy = 1'b0;
    wr(16'h0002, 16'h0002, 0);
    rd(16'h0000, v);
    check("stat_clr", 256'(v), 256'(16'h0000));

    res = 32'hCAFE_1234;
    done = 1'b1;
    tick();
    done = 1'b0;
    m_done = 1'b1;
    m_res = res;
    res = 32'h0;
    rd(16'h0000, v);
    check("stat_done", 256'(v), 256'(16'h0002));
    rd(16'h0180, v);
    check("res_lo", 256'(v), 256'(16'h1234));
    rd(16'h0181, v);
    check("res_hi", 256'(v), 256'(16'hCAFE));
    wr(16'h0002, 16'h0001, 0);
    rd(16'h0000, v);
    check("done_clr", 256'(v), 256'(16'h0000));

    rd(16'h0180, v);
    wr(16'h0100, 16'h7777, 1);
    check("rd_hold", 256'(dout), 256'(16'h1234));
    check("rd_hold_op", 256'(op), 256'(exp_op()));

    for (int i = 0; i < 80; i++) begin
      busy = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 9));
      if (r <= 5) a = ($urandom_range(0, 1) == 1)
                    ? 16'(16'h0100 + $urandom_range(0, 11))
                    : 16'(16'h0110 + $urandom_range(0, 1));
      else if (r == 6) a = 16'($urandom);
      else if (r == 7) a = 16'h0002;
      else if (r == 8) a = ($urandom_range(0, 4) == 4) ? 16'hFFFF
                           : 16'(16'h010C + $urandom_range(0, 3));
      if (r == 9) begin
        case ($urandom_range(0, 4))
          0: a = 16'h0000;
          1: a = 16'(16'h0180 + $urandom_range(0, 1));
          2: a = 16'(16'h0100 + $urandom_range(0, 17));
          3: a = 16'h0002;
          default: a = 16'($urandom);
        endcase
        rdchk("rand_rd", a);
      end else begin
        wr(a, (r == 7) ? 16'($urandom_range(0, 3)) : 16'($urandom), 0);
        check("rand_op", 256'(op), 256'(exp_op()));
        check("rand_err", 256'(err), 256'(m_err));
      end
    end
    busy = 1'b0;

    wrn = 1'b1; di = 16'h0102;
    tick();
    rstn = 1'b0; wrn = 1'b0; di = 16'hABCD;
    #2;
    check("midrst_op", 256'(op), 256'(0));
    tick();
    rstn = 1'b1;
    model_reset();
    tick();
    check("post_rst_op", 256'(op), 256'(0));
    wr(16'h0102, 16'h4321, 0);
    check("post_rst_wr", 256'(op), 256'(exp_op()));
    check("post_rst_w1", 256'(op[47:32]), 256'(16'h4321));

    wr(16'h0002, 16'h0001, 0);
    rstn = 1'b0;
    #1;
    check("rst_kills_start", 256'(start), 256'(0));
    tick();
    rstn = 1'b1;
    model_reset();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
